// File: rtl/line_buffer_writer.sv
// line_buffer_writer: producer-side front end for the circular line buffer.
// Every line must put exactly LINE_W writes into the buffer. Short lines are
// padded with PAD_VAL and the excess of long lines is dropped, so that tap
// offsets in the buffer stay column-aligned. All outputs are registered.
module line_buffer_writer #(
  parameter int              DW      = 16,
  parameter int              LINE_W  = 1027,
  parameter int              ROWS    = 768,
  parameter int              CW      = 11,
  parameter int              RW      = 10,
  parameter logic [DW-1:0]   PAD_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_sof,
  input  logic          s_eol,
  output logic          lb_en,
  output logic          lb_wen,
  output logic [DW-1:0] lb_din,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          primed,
  output logic          frame_done,
  output logic          err_short,
  output logic          err_long,
  output logic          err_sync
);

  typedef enum logic [1:0] {IDLE, FILL, PAD, DROP} state_t;

  // Counters are compared against the exact last index and are never left
  // to wrap at the power of two.
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          primed_q, primed_d;
  logic          ready_q, ready_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] din_q, din_d;
  logic          fd_q, fd_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          sync_q, sync_d;

  logic          accept;
  logic          atOrigin;
  logic          beat;
  logic          restart;
  logic          endLine;
  logic          goDrop;
  logic [CW-1:0] pos;
  logic [RW-1:0] rowCur;

  // Next-state logic: decide whether this cycle writes a beat or a pad,
  // where that write lands, and what the line-end step does afterwards.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    primed_d = primed_q;
    wen_d    = 1'b0;
    din_d    = din_q;
    fd_d     = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    sync_d   = 1'b0;
    beat     = 1'b0;
    restart  = 1'b0;
    endLine  = 1'b0;
    goDrop   = 1'b0;
    pos      = col_q;
    rowCur   = row_q;
    accept   = s_valid & ready_q;
    atOrigin = (col_q == '0) && (row_q == '0);

    unique case (state_q)
      IDLE: begin
        if (accept && s_sof) begin
          restart = 1'b1;
          beat    = 1'b1;
        end
      end
      FILL: begin
        if (accept) begin
          beat = 1'b1;
          if (s_sof && !atOrigin) begin
            restart = 1'b1;
            sync_d  = 1'b1;
          end
        end
      end
      DROP: begin
        if (accept) begin
          if (s_sof) begin
            beat = 1'b1;
            if (!atOrigin) begin
              restart = 1'b1;
              sync_d  = 1'b1;
            end
          end else if (s_eol) begin
            state_d = FILL;
          end
        end
      end
      PAD: begin
        wen_d = 1'b1;
        din_d = PAD_VAL;
        if (col_q == LAST_COL) begin
          endLine = 1'b1;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A frame start (new frame or resync) repositions the write to (0, 0)
    // and forgets any previously stored line.
    if (restart) begin
      pos      = '0;
      rowCur   = '0;
      row_d    = '0;
      primed_d = 1'b0;
    end

    if (beat) begin
      wen_d = 1'b1;
      din_d = s_data;
      if (pos == LAST_COL) begin
        endLine = 1'b1;
        if (!s_eol) begin
          long_d = 1'b1;
          goDrop = 1'b1;
        end
      end else begin
        col_d = pos + CW'(1);
        if (s_eol) begin
          short_d = 1'b1;
          state_d = PAD;
        end else begin
          state_d = FILL;
        end
      end
    end

    if (endLine) begin
      col_d = '0;
      if (rowCur == '0) begin
        primed_d = 1'b1;
      end
      if (rowCur == LAST_ROW) begin
        fd_d    = 1'b1;
        row_d   = '0;
        state_d = IDLE;
      end else begin
        row_d   = rowCur + RW'(1);
        state_d = goDrop ? DROP : FILL;
      end
    end

    ready_d = (state_d != PAD);
  end

  // State and output registers; reset abandons any line in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      primed_q <= 1'b0;
      ready_q  <= 1'b0;
      wen_q    <= 1'b0;
      din_q    <= '0;
      fd_q     <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      primed_q <= primed_d;
      ready_q  <= ready_d;
      wen_q    <= wen_d;
      din_q    <= din_d;
      fd_q     <= fd_d;
      short_q  <= short_d;
      long_q   <= long_d;
      sync_q   <= sync_d;
    end
  end

  assign s_ready    = ready_q;
  assign lb_en      = wen_q;
  assign lb_wen     = wen_q;
  assign lb_din     = din_q;
  assign col        = col_q;
  assign row        = row_q;
  assign primed     = primed_q;
  assign frame_done = fd_q;
  assign err_short  = short_q;
  assign err_long   = long_q;
  assign err_sync   = sync_q;

endmodule

// File: tb/tb_line_buffer_writer.sv
// Testbench for line_buffer_writer with a small geometry (8 x 2). A
// behavioural model tracks the expected position, padding and dropping, and
// a compare process checks every output on every falling edge.
module tb_line_buffer_writer;

  localparam int          DW      = 16;
  localparam int          LINE_W  = 8;
  localparam int          ROWS    = 2;
  localparam int          CW      = 3;
  localparam int          RW      = 1;
  localparam logic [15:0] PAD     = 16'hBEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_sof = 1'b0;
  logic          s_eol = 1'b0;
  logic          lb_en, lb_wen;
  logic [DW-1:0] lb_din;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          primed, frame_done, err_short, err_long, err_sync;

  int checks = 0;
  int errors = 0;

  line_buffer_writer #(
    .DW(DW), .LINE_W(LINE_W), .ROWS(ROWS), .CW(CW), .RW(RW), .PAD_VAL(PAD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .s_eol(s_eol),
    .lb_en(lb_en), .lb_wen(lb_wen), .lb_din(lb_din),
    .col(col), .row(row), .primed(primed), .frame_done(frame_done),
    .err_short(err_short), .err_long(err_long), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  // Model state: position of the next write, pads still owed, whether a
  // frame is open and whether the rest of an overlong line is being dropped.
  int          mCol = 0, mRow = 0, padsLeft = 0;
  bit          mPrimed = 0, active = 0, dropping = 0;
  bit          eReady = 0, eWen = 0, eFd = 0, eShort = 0, eLong = 0, eSync = 0;
  logic [15:0] eDin = '0;

  logic [15:0] wrLog[$];
  int          fdCount = 0, shortCount = 0, longCount = 0, syncCount = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic modelLineEnd();
    mCol = 0;
    if (mRow == 0) mPrimed = 1;
    if (mRow == ROWS - 1) begin
      eFd      = 1;
      mRow     = 0;
      active   = 0;
      dropping = 0;
    end else begin
      mRow++;
    end
  endtask

  task automatic modelStep();
    bit acc;
    acc    = s_valid && eReady;
    eWen   = 0;
    eFd    = 0;
    eShort = 0;
    eLong  = 0;
    eSync  = 0;
    if (padsLeft > 0) begin
      eWen = 1;
      eDin = PAD;
      padsLeft--;
      if (padsLeft == 0) modelLineEnd();
      else mCol++;
    end else if (acc) begin
      if (s_sof) begin
        if (active && (mCol != 0 || mRow != 0)) eSync = 1;
        if (!active || eSync) begin
          mPrimed = 0;
          mCol    = 0;
          mRow    = 0;
        end
        active   = 1;
        dropping = 0;
      end
      if (!active) begin
        // beat outside a frame: discarded
      end else if (dropping) begin
        if (s_eol) dropping = 0;
      end else begin
        eWen = 1;
        eDin = s_data;
        if (mCol == LINE_W - 1) begin
          modelLineEnd();
          if (!s_eol) begin
            eLong = 1;
            if (active) dropping = 1;
          end
        end else begin
          if (s_eol) begin
            eShort   = 1;
            padsLeft = LINE_W - 1 - mCol;
          end
          mCol++;
        end
      end
    end
    eReady = (padsLeft == 0);
  endtask

  // Reference model advances on the same edges as the design.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCol = 0; mRow = 0; padsLeft = 0;
      mPrimed = 0; active = 0; dropping = 0;
      eReady = 0; eWen = 0; eFd = 0; eShort = 0; eLong = 0; eSync = 0;
      eDin = '0;
    end else begin
      modelStep();
    end
  end

  // Compare every output against the model away from the active edge and
  // log the writes and pulses actually produced.
  always @(negedge clk) begin
    checkOutput("s_ready", int'(s_ready), int'(eReady));
    checkOutput("lb_wen", int'(lb_wen), int'(eWen));
    checkOutput("lb_en", int'(lb_en), int'(eWen));
    if (eWen) checkOutput("lb_din", int'(lb_din), int'(eDin));
    checkOutput("col", int'(col), mCol);
    checkOutput("row", int'(row), mRow);
    checkOutput("primed", int'(primed), int'(mPrimed));
    checkOutput("frame_done", int'(frame_done), int'(eFd));
    checkOutput("err_short", int'(err_short), int'(eShort));
    checkOutput("err_long", int'(err_long), int'(eLong));
    checkOutput("err_sync", int'(err_sync), int'(eSync));
    if (lb_wen) wrLog.push_back(lb_din);
    if (frame_done) fdCount++;
    if (err_short) shortCount++;
    if (err_long) longCount++;
    if (err_sync) syncCount++;
  end

  // Present one beat; it is accepted on the rising edge after the falling
  // edge where s_ready was seen high.
  task automatic applyStimulus(input logic [15:0] d, input bit sof, input bit eol,
                               input int gapMax);
    int b;
    @(negedge clk);
    repeat ($urandom_range(0, gapMax)) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    b = 0;
    while (!s_ready && b < 50) begin
      s_valid = 1'b0;
      @(negedge clk);
      b++;
    end
    if (b == 50) begin
      checkOutput("readyTimeout", 0, 1);
    end else begin
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      s_eol   = eol;
    end
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clearLog();
    wrLog.delete();
    fdCount = 0; shortCount = 0; longCount = 0; syncCount = 0;
  endtask

  // Full frame of two 8-pixel lines, data 100..115.
  task automatic nominalFrame(input int gapMax);
    for (int i = 0; i < 16; i++)
      applyStimulus(16'(100 + i), i == 0, (i == 7) || (i == 15), gapMax);
    idleCycles(6);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idleCycles(2);

    // Nominal frame, no gaps
    clearLog();
    nominalFrame(0);
    checkOutput("nomWrites", wrLog.size(), 16);
    checkOutput("nomFirst", int'(wrLog[0]), 100);
    checkOutput("nomLast", int'(wrLog[15]), 115);
    checkOutput("nomFrameDone", fdCount, 1);
    checkOutput("nomErrors", shortCount + longCount + syncCount, 0);
    checkOutput("nomPrimedHeld", int'(primed), 1);

    // Same frame with gaps plus junk beats while idle
    clearLog();
    applyStimulus(16'h0111, 1'b0, 1'b0, 0);
    applyStimulus(16'h0222, 1'b0, 1'b1, 0);
    nominalFrame(3);
    checkOutput("gapWrites", wrLog.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < wrLog.size()) checkOutput("gapData", int'(wrLog[i]), 100 + i);

    // Short first line: eol on the 5th pixel
    clearLog();
    for (int i = 0; i < 5; i++) applyStimulus(16'(200 + i), i == 0, i == 4, 0);
    for (int i = 0; i < 8; i++) applyStimulus(16'(300 + i), 1'b0, i == 7, 0);
    idleCycles(6);
    checkOutput("shortWrites", wrLog.size(), 16);
    checkOutput("shortPulse", shortCount, 1);
    checkOutput("shortLastData", int'(wrLog[4]), 204);
    checkOutput("shortPad0", int'(wrLog[5]), int'(PAD));
    checkOutput("shortPad2", int'(wrLog[7]), int'(PAD));
    checkOutput("shortNextRow", int'(wrLog[8]), 300);

    // Long first line: 11 beats, eol on the 11th
    clearLog();
    for (int i = 0; i < 11; i++) applyStimulus(16'(400 + i), i == 0, i == 10, 0);
    for (int i = 0; i < 8; i++) applyStimulus(16'(500 + i), 1'b0, i == 7, 0);
    idleCycles(6);
    checkOutput("longWrites", wrLog.size(), 16);
    checkOutput("longPulse", longCount, 1);
    checkOutput("longLastKept", int'(wrLog[7]), 407);
    checkOutput("longNextRow", int'(wrLog[8]), 500);

    // Resync: sof on the 4th pixel of row 1
    clearLog();
    for (int i = 0; i < 8; i++) applyStimulus(16'(600 + i), i == 0, i == 7, 0);
    for (int i = 0; i < 3; i++) applyStimulus(16'(700 + i), 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(16'(800 + i), i == 0, i == 7, 0);
    for (int i = 0; i < 8; i++) applyStimulus(16'(900 + i), 1'b0, i == 7, 0);
    idleCycles(6);
    checkOutput("syncWrites", wrLog.size(), 27);
    checkOutput("syncPulse", syncCount, 1);
    checkOutput("syncBeat", int'(wrLog[11]), 800);

    // Reset while two pads are still owed
    clearLog();
    for (int i = 0; i < 5; i++) applyStimulus(16'(1000 + i), i == 0, i == 4, 0);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("rstWen", int'(lb_wen), 0);
    checkOutput("rstReady", int'(s_ready), 0);
    checkOutput("rstCol", int'(col), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idleCycles(6);
    checkOutput("rstWrites", wrLog.size(), 5);

    // Randomized frames with gaps, junk, varying lengths and stray sof
    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(0, 2))
        applyStimulus(16'($urandom), 1'b0, $urandom_range(0, 1) == 1, 2);
      for (int r = 0; r < ROWS; r++) begin
        int len;
        len = $urandom_range(3, 11);
        for (int k = 0; k < len; k++)
          applyStimulus(16'($urandom),
                        ((r == 0) && (k == 0)) || ($urandom_range(0, 39) == 0),
                        k == len - 1, 2);
      end
    end
    idleCycles(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/line_buffer_writer.md
Name: line_buffer_writer

Overview:
- Producer-side front end for the 16-bit circular line buffer; sits between the upstream pixel stream and the buffer's write port.
- Accepts a framed valid/ready pixel stream and enforces exactly LINE_W writes per line by padding short lines and dropping excess on long ones, so buffer tap offsets stay column-aligned.
- Tracks column and row position, reports when one full line is resident (primed), and flags framing errors.

Parameters:
- DW, 16, pixel data width.
- LINE_W, 1027, pixels per line; equals line buffer depth.
- ROWS, 768, lines per frame.
- CW, 11, column counter width; must satisfy 2^CW >= LINE_W.
- RW, 10, row counter width; must satisfy 2^RW >= ROWS.
- PAD_VAL, 0, value written for padded columns.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  upstream beat accepted when s_valid & s_ready.
- s_data  in  DW  pixel.
- s_sof  in  1  first pixel of frame, qualified by s_valid.
- s_eol  in  1  last pixel of line, qualified by s_valid.
- lb_en  out  1  line buffer enable (advances buffer pointers).
- lb_wen  out  1  line buffer write enable.
- lb_din  out  DW  line buffer write data.
- col  out  CW  column index of the next write.
- row  out  RW  current row index.
- primed  out  1  at least one complete line is stored this frame.
- frame_done  out  1  one-cycle pulse after the last write of row ROWS-1.
- err_short  out  1  one-cycle pulse: eol arrived before column LINE_W-1.
- err_long  out  1  one-cycle pulse: column LINE_W-1 reached without eol.
- err_sync  out  1  one-cycle pulse: sof arrived mid-frame.

Behaviour:
- Reset: state IDLE; all outputs 0 (s_ready, lb_en, lb_wen, lb_din, col, row, primed, pulses). Reset mid-operation abandons the line immediately; no further padding is written.
- All outputs are registered. A write appears on lb_en/lb_wen/lb_din one cycle after the accepting handshake or pad decision. lb_en == lb_wen always; at most one write per cycle.
- FSM states:
  - IDLE: s_ready=1. Non-sof beats are accepted and discarded. A sof beat is written at col 0, row 0, and the FSM goes to FILL. primed is cleared on entry to a new frame.
  - FILL: s_ready=1. Each accepted beat is written, then col increments.
  - PAD: s_ready=0. Writes PAD_VAL each cycle until col reaches LINE_W-1, then performs the line-end step.
  - DROP: s_ready=1. Beats are discarded without writes until an eol beat (inclusive), then FSM returns to FILL.
- Line-end step (an accepted beat at col LINE_W-1 with eol, or the last pad write):
  - col resets to 0 and row increments.
  - primed is set at the end of row 0.
  - If row was ROWS-1: pulse frame_done, row resets to 0, FSM goes to IDLE.
- Short line: an eol beat at col < LINE_W-1 is written, err_short pulses, and the FSM enters PAD. It writes LINE_W-1-col pad pixels.
- Long line: a beat at col LINE_W-1 without eol is written, then the line-end step runs, err_long pulses, and the FSM enters DROP (or IDLE if that was the final row). Excess beats never wrap into the next line.
- sof in FILL or DROP when (col, row) != (0, 0):
  - err_sync pulses and primed clears.
  - The beat is written as col 0, row 0, and the FSM goes to FILL.
  - sof at (0, 0) in FILL is legal.
- sof and eol on the same beat: the beat is treated as sof first, then the eol rule is applied at col 0. With LINE_W > 1 this is a short line.
- s_valid may drop at any time in FILL; no write occurs and col holds.
- Counter arithmetic: col is an unsigned CW-bit value, compared against LINE_W-1 exactly, never left to wrap at 2^CW. row is an unsigned RW-bit value, compared against ROWS-1.

Test Plan:
- Nominal: with LINE_W=8, ROWS=2, send 16 beats (sof on the first, eol on beats 8 and 16), s_valid held high -> 16 writes of data in order; primed rises after write 8; frame_done pulses once after write 16; no error pulses.
- Short line: with LINE_W=8, eol on the 5th pixel -> err_short pulses; 5 data writes then 3 writes of PAD_VAL; s_ready=0 for 3 cycles; the next pixel is written at col 0, row 1.
- Long line: with LINE_W=8, 11 beats with eol on the 11th -> 8 writes; err_long pulses; beats 9-11 produce no writes; the next beat is written at col 0.
- Resync: sof on the 4th pixel of row 1 -> err_sync pulses; primed goes 0; that beat is written with col=0, row=0.
- Backpressure and idle: random s_valid gaps, plus beats without sof while in IDLE -> no writes in IDLE; col holds during gaps; the write sequence is identical to the gap-free run.
- Reset mid-PAD: assert rst while 2 pads remain -> on the next cycle lb_wen=0, all outputs are 0, the FSM is in IDLE, and no remaining pads are written.
